// File: rtl/mem_port_arbiter.sv
// Merges an instruction-fetch port (A) and a data port (B) onto one memory port.
// B has priority, but after MAX_B_STREAK back-to-back B grants with A waiting, A is served.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MAX_B_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    read_a,
    input  logic [ADDR_WIDTH-1:0]   address_a,
    output logic                    resp_a,
    output logic [DATA_WIDTH-1:0]   rdata_a,
    input  logic                    read_b,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]   address_b,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    resp_b,
    output logic [DATA_WIDTH-1:0]   rdata_b,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [DATA_WIDTH/8-1:0] pmem_wmask,
    output logic [ADDR_WIDTH-1:0]   pmem_address,
    output logic [DATA_WIDTH-1:0]   pmem_wdata,
    input  logic                    pmem_resp,
    input  logic [DATA_WIDTH-1:0]   pmem_rdata
);

    localparam int unsigned MaskWidth   = DATA_WIDTH / 8;
    localparam int unsigned StreakWidth = $clog2(MAX_B_STREAK + 1);
    localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MAX_B_STREAK);

    typedef enum logic [1:0] {StIdle, StServeA, StServeB} state_e;

    state_e                   state_q, state_d;
    logic [StreakWidth-1:0]   streak_q, streak_d;
    logic                     read_q, read_d;
    logic                     write_q, write_d;
    logic [MaskWidth-1:0]     wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0]    address_q, address_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     req_a, req_b;

    assign req_a = read_a;
    assign req_b = read_b | write;

    assign pmem_read    = read_q;
    assign pmem_write   = write_q;
    assign pmem_wmask   = wmask_q;
    assign pmem_address = address_q;
    assign pmem_wdata   = wdata_q;

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        read_d    = read_q;
        write_d   = write_q;
        wmask_d   = wmask_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        resp_a    = 1'b0;
        resp_b    = 1'b0;
        rdata_a   = '0;
        rdata_b   = '0;

        unique case (state_q)
            StIdle: begin
                // Streak only advances while A is actually being held off.
                if (req_b && (!req_a || streak_q < StreakMax)) begin
                    state_d   = StServeB;
                    read_d    = read_b & ~write;
                    write_d   = write;
                    wmask_d   = wmask;
                    address_d = address_b;
                    wdata_d   = wdata;
                    if (req_a) begin
                        streak_d = (streak_q == StreakMax) ? streak_q
                                                           : streak_q + StreakWidth'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (req_a) begin
                    state_d   = StServeA;
                    read_d    = 1'b1;
                    write_d   = 1'b0;
                    wmask_d   = '0;
                    address_d = address_a;
                    wdata_d   = '0;
                    streak_d  = '0;
                end else begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            StServeA: begin
                if (pmem_resp) begin
                    resp_a  = 1'b1;
                    rdata_a = pmem_rdata;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = StIdle;
                end
            end
            StServeB: begin
                if (pmem_resp) begin
                    resp_b  = 1'b1;
                    rdata_b = pmem_rdata;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            streak_q  <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wmask_q   <= '0;
            address_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            read_q    <= read_d;
            write_q   <= write_d;
            wmask_q   <= wmask_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule
